// File: rtl/inst_j_dec.sv
// Registered RV32I J-type (JAL) decoder: fields, opcode check, byte offset.
// Define INST_J_DEC_OFFSET_EN to build the offset reassembly; else offset=0.
module inst_j_dec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instruction_word,
  output logic        out_valid,
  output logic [19:0] imm_J,
  output logic [4:0]  rd,
  output logic        is_jal,
  output logic [31:0] offset
);

  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        valid_q;
  logic [19:0] imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic        jal_q, jal_d;

  always_comb begin
    imm_d = imm_q;
    rd_d  = rd_q;
    jal_d = jal_q;
    if (in_valid) begin
      imm_d = instruction_word[31:12];
      rd_d  = instruction_word[11:7];
      jal_d = (instruction_word[6:0] == OP_JAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      rd_q    <= '0;
      jal_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      jal_q   <= jal_d;
    end
  end

  assign out_valid = valid_q;
  assign imm_J     = imm_q;
  assign rd        = rd_q;
  assign is_jal    = jal_q;

`ifdef INST_J_DEC_OFFSET_EN
  logic [31:0] off_q, off_d;

  // Unshuffle imm[20|10:1|11|19:12] and sign-extend from bit 20.
  always_comb begin
    off_d = off_q;
    if (in_valid) begin
      off_d = {{11{instruction_word[31]}},
               instruction_word[31],
               instruction_word[19:12],
               instruction_word[20],
               instruction_word[30:21],
               1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) off_q <= '0;
    else        off_q <= off_d;
  end

  assign offset = off_q;
`else
  assign offset = 32'h0;
`endif

endmodule

// File: tb/tb_inst_j_dec.sv
// Scoreboard bench for inst_j_dec against an arithmetic reference model.
module tb_inst_j_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] iw;
  logic        out_valid;
  logic [19:0] imm_J;
  logic [4:0]  rd;
  logic        is_jal;
  logic [31:0] offset;

  typedef struct packed {
    logic        v;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic        jal;
    logic [31:0] off;
  } exp_t;

  exp_t q[$];
  exp_t m;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  inst_j_dec dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .instruction_word(iw),
    .out_valid(out_valid),
    .imm_J(imm_J),
    .rd(rd),
    .is_jal(is_jal),
    .offset(offset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_off(logic [31:0] w);
`ifdef INST_J_DEC_OFFSET_EN
    longint s;
    s = longint'((w >> 21) & 32'd1023) * 2
      + longint'((w >> 20) & 32'd1) * 2048
      + longint'((w >> 12) & 32'd255) * 4096
      - ((w >> 31) != 0 ? longint'(1) << 20 : longint'(0));
    return 32'(s);
`else
    return 32'h0;
`endif
  endfunction

  function automatic exp_t step(exp_t cur, logic v, logic [31:0] w);
    exp_t n;
    n = cur;
    n.v = v;
    if (v) begin
      n.imm = 20'(w >> 12);
      n.rd  = 5'((w >> 7) % 32);
      n.jal = ((w % 128) == 32'd111);
      n.off = ref_off(w);
    end
    return n;
  endfunction

  task automatic cmp(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic check_all(string tag, exp_t e);
    cmp({tag, ".out_valid"}, 32'(out_valid), 32'(e.v));
    cmp({tag, ".imm_J"}, 32'(imm_J), 32'(e.imm));
    cmp({tag, ".rd"}, 32'(rd), 32'(e.rd));
    cmp({tag, ".is_jal"}, 32'(is_jal), 32'(e.jal));
    cmp({tag, ".offset"}, offset, e.off);
  endtask

  task automatic drive(logic v, logic [31:0] w);
    @(negedge clk);
    in_valid = v;
    iw = w;
    m = step(m, v, w);
    q.push_back(m);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      cmp("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check_all("mon", mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    rst_n = 1'b0;
    in_valid = 1'b1;
    iw = 32'hFFFF_FFFF;
    m = '0;
    #1;
    check_all("reset", '0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    drive(1'b1, 32'b00001111110101101110_01101_1101111);
    drive(1'b1, 32'b11001110010101001111_00100_1101111);
    drive(1'b1, 32'b01001110010101101111_11111_1101111);
    drive(1'b1, 32'h0000_0013);
    drive(1'b0, 32'hDEAD_BEEF);
    drive(1'b0, 32'h1234_566F);
    drive(1'b1, 32'h8000_006F);
    drive(1'b1, 32'h7FFF_F0EF);

    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[6:0] = 7'b1101111;
      drive($urandom_range(3, 0) != 0, w);
    end

    drain();
    @(negedge clk);
    in_valid = 1'b1;
    iw = $urandom;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midrst", '0);
    m = '0;
    @(posedge clk);
    #1;
    check_all("inrst", '0);
    @(negedge clk);
    w = {$urandom, 7'b1101111} >> 0;
    w[6:0] = 7'b1101111;
    rst_n = 1'b1;
    in_valid = 1'b1;
    iw = w;
    m = step(m, 1'b1, w);
    q.push_back(m);

    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[6:0] = 7'b1101111;
      drive($urandom_range(3, 0) != 0, w);
    end
    drive(1'b0, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
